// File: rtl/convolution_coprocessor_pkg.sv
// Shared types and helpers for the convolution coprocessor add/sub pipeline.
package convolution_coprocessor_pkg;

  // Operation applied uniformly to every lane of a beat.
  typedef enum logic [1:0] {
    OP_SUB     = 2'b00,  // A - B
    OP_ADD     = 2'b01,  // A + B
    OP_ABSDIFF = 2'b10,  // |A - B|
    OP_RSUB    = 2'b11   // B - A
  } addsub_op_e;

  // Width of the container used to hand extended lane values to sat_clip.
  localparam int CLIP_W = 32;

  // Clamp a sign-extended value into the signed range of a width-bit field.
  function automatic logic signed [CLIP_W-1:0] sat_clip(
    input logic signed [CLIP_W-1:0] value,
    input int                       width
  );
    logic signed [CLIP_W-1:0] max_v;
    logic signed [CLIP_W-1:0] min_v;
    max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
    min_v = -max_v - 32'sd1;
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/convolution_coprocessor_addsub_lane.sv
// One combinational lane: extend, apply op, then saturate or wrap and flag overflow.
module convolution_coprocessor_addsub_lane
  import convolution_coprocessor_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter bit SAT_EN     = 1'b1
) (
  input  addsub_op_e            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] res,
  output logic                  ovf
);

  // Two guard bits hold every exact result, including |(-2^(W-1)) - (2^(W-1)-1)|.
  localparam int EW = DATA_WIDTH + 2;

  logic signed [EW-1:0]     a_x;
  logic signed [EW-1:0]     b_x;
  logic signed [EW-1:0]     diff_x;
  logic signed [EW-1:0]     exact_x;
  logic signed [CLIP_W-1:0] exact_w;
  logic signed [CLIP_W-1:0] clip_w;

  // Exact arithmetic in the extended width, then range check against the lane width.
  always_comb begin
    a_x    = {{2{a[DATA_WIDTH-1]}}, a};
    b_x    = {{2{b[DATA_WIDTH-1]}}, b};
    diff_x = a_x - b_x;
    case (op)
      OP_SUB:     exact_x = diff_x;
      OP_ADD:     exact_x = a_x + b_x;
      OP_ABSDIFF: exact_x = diff_x[EW-1] ? -diff_x : diff_x;
      OP_RSUB:    exact_x = b_x - a_x;
      default:    exact_x = diff_x;
    endcase
    exact_w = {{(CLIP_W-EW){exact_x[EW-1]}}, exact_x};
    clip_w  = sat_clip(exact_w, DATA_WIDTH);
    ovf     = (clip_w != exact_w);
    res     = SAT_EN ? clip_w[DATA_WIDTH-1:0] : exact_x[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/convolution_coprocessor_addsub_pipe.sv
// Multi-lane two-stage add/sub/abs-diff pipeline with valid/ready flow and sticky overflow.
module convolution_coprocessor_addsub_pipe
  import convolution_coprocessor_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int LANES      = 4,
  parameter bit SAT_EN     = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  in_op,
  input  logic [LANES*DATA_WIDTH-1:0] in_a,
  input  logic [LANES*DATA_WIDTH-1:0] in_b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_res,
  output logic [LANES-1:0]            out_ovf,
  output logic [LANES-1:0]            ovf_sticky,
  input  logic                        clr_ovf
);

  localparam int VW = LANES * DATA_WIDTH;

  // Handshake: a beat moves across an interface on a rising edge where its
  // valid and ready are both high. A stage may load whenever it is empty or
  // its current beat leaves in the same cycle, so ready is derived from
  // registered valids and out_ready only and never looks at in_valid.

  logic             s1_valid_q, s1_valid_d;
  addsub_op_e       s1_op_q, s1_op_d;
  logic [VW-1:0]    s1_a_q, s1_a_d;
  logic [VW-1:0]    s1_b_q, s1_b_d;
  logic             s2_valid_q, s2_valid_d;
  logic [VW-1:0]    s2_res_q, s2_res_d;
  logic [LANES-1:0] s2_ovf_q, s2_ovf_d;
  logic [LANES-1:0] ovf_sticky_q, ovf_sticky_d;
  logic [VW-1:0]    lane_res;
  logic [LANES-1:0] lane_ovf;
  logic             s2_adv;
  logic             s1_adv;

  // Per-lane arithmetic fed from the S1 registers.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    convolution_coprocessor_addsub_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .SAT_EN     (SAT_EN)
    ) u_lane (
      .op  (s1_op_q),
      .a   (s1_a_q[i*DATA_WIDTH +: DATA_WIDTH]),
      .b   (s1_b_q[i*DATA_WIDTH +: DATA_WIDTH]),
      .res (lane_res[i*DATA_WIDTH +: DATA_WIDTH]),
      .ovf (lane_ovf[i])
    );
  end

  // Stage advance conditions.
  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = s1_adv;
  end

  // Next-state for both stages and the sticky overflow flags.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_op_d      = s1_op_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s2_valid_d   = s2_valid_q;
    s2_res_d     = s2_res_q;
    s2_ovf_d     = s2_ovf_q;
    ovf_sticky_d = ovf_sticky_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d = addsub_op_e'(in_op);
        s1_a_d  = in_a;
        s1_b_d  = in_b;
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_res_d = lane_res;
        s2_ovf_d = lane_ovf;
      end
    end

    // Clear first so a same-cycle overflowing transfer still leaves the flag set.
    if (clr_ovf) begin
      ovf_sticky_d = '0;
    end
    if (s2_valid_q && out_ready) begin
      ovf_sticky_d = ovf_sticky_d | s2_ovf_q;
    end
  end

  // Pipeline and flag registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= OP_SUB;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s2_valid_q   <= 1'b0;
      s2_res_q     <= '0;
      s2_ovf_q     <= '0;
      ovf_sticky_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s2_valid_q   <= s2_valid_d;
      s2_res_q     <= s2_res_d;
      s2_ovf_q     <= s2_ovf_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_res    = s2_res_q;
  assign out_ovf    = s2_ovf_q;
  assign ovf_sticky = ovf_sticky_q;

endmodule
